memory_access: RTL

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// Memory-access pipeline stage: passes ALU results through and runs one data-memory access at a time.
// Optional build macro MEMORY_ACCESS_MISALIGN_TRAP_EN turns misaligned memory ops into a one-cycle flagged bubble.
module memory_access #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_e,
  output logic                     ready_e,
  input  logic                     reg_write_e,
  input  logic [1:0]               result_src_e,
  input  logic                     mem_write_e,
  input  logic [2:0]               funct3_e,
  input  logic [ADDRESS_WIDTH-1:0] alu_result_e,
  input  logic [DATA_WIDTH-1:0]    write_data_e,
  input  logic [4:0]               rd_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr,
  output logic [3:0]               dmem_be,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  input  logic                     dmem_ready,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  output logic                     reg_write_m,
  output logic [1:0]               result_src_m,
  output logic [ADDRESS_WIDTH-1:0] alu_result_m,
  output logic [DATA_WIDTH-1:0]    read_data_m,
  output logic [4:0]               rd_m,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
  output logic                     stall_m,
  output logic                     misaligned_m
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t          state;
  logic            mem_op_c;
  logic            trap_c;
  logic [1:0]      size_c;
  logic [AW-1:0]   addr_aligned_c;
  logic [3:0]      be_c;
  logic [DW-1:0]   wdata_c;

  logic            cap_reg_write;
  logic            cap_store;
  logic [1:0]      cap_result_src;
  logic [2:0]      cap_funct3;
  logic [AW-1:0]   cap_alu;
  logic [4:0]      cap_rd;
  logic [AW-1:0]   cap_pc4;

  assign stall_m = (state == ACCESS);
  assign ready_e = !stall_m;

  // Extract and extend the addressed byte/half of a read word.
  function automatic logic [DW-1:0] load_format(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [DW-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_format = {{(DW-8){b[7]}}, b};
      3'b100:  load_format = {{(DW-8){1'b0}}, b};
      3'b001:  load_format = {{(DW-16){h[15]}}, h};
      3'b101:  load_format = {{(DW-16){1'b0}}, h};
      default: load_format = word;
    endcase
  endfunction

  // Access size (0 byte, 1 half, 2 word), aligned address and store lane steering.
  always_comb begin
    mem_op_c = (result_src_e == 2'b01) || mem_write_e;
    case (funct3_e)
      3'b000, 3'b100: size_c = 2'd0;
      3'b001, 3'b101: size_c = 2'd1;
      default:        size_c = 2'd2;
    endcase
    addr_aligned_c = alu_result_e;
    if (size_c == 2'd1) addr_aligned_c[0] = 1'b0;
    if (size_c == 2'd2) addr_aligned_c[1:0] = 2'b00;
    be_c    = 4'b1111;
    wdata_c = write_data_e;
    if (mem_write_e) begin
      case (size_c)
        2'd0: begin
          be_c    = 4'b0001 << addr_aligned_c[1:0];
          wdata_c = {4{write_data_e[7:0]}};
        end
        2'd1: begin
          be_c    = addr_aligned_c[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{write_data_e[15:0]}};
        end
        default: ;
      endcase
    end
  end

`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
  assign trap_c = mem_op_c && (((size_c == 2'd1) && alu_result_e[0]) ||
                               ((size_c == 2'd2) && (alu_result_e[1:0] != 2'b00)));
`else
  assign trap_c = 1'b0;
`endif

  // Stage FSM with registered memory request and writeback fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_be        <= '0;
      dmem_wdata     <= '0;
      reg_write_m    <= 1'b0;
      result_src_m   <= '0;
      alu_result_m   <= '0;
      read_data_m    <= '0;
      rd_m           <= '0;
      pc_plus4_m     <= '0;
      misaligned_m   <= 1'b0;
      cap_reg_write  <= 1'b0;
      cap_store      <= 1'b0;
      cap_result_src <= '0;
      cap_funct3     <= '0;
      cap_alu        <= '0;
      cap_rd         <= '0;
      cap_pc4        <= '0;
    end else begin
      misaligned_m <= 1'b0;
      case (state)
        IDLE: begin
          reg_write_m <= 1'b0;
          if (valid_e) begin
            if (trap_c) begin
              misaligned_m <= 1'b1;
            end else if (mem_op_c) begin
              cap_reg_write  <= reg_write_e;
              cap_store      <= mem_write_e;
              cap_result_src <= result_src_e;
              cap_funct3     <= funct3_e;
              cap_alu        <= alu_result_e;
              cap_rd         <= rd_e;
              cap_pc4        <= pc_plus4_e;
              dmem_req       <= 1'b1;
              dmem_we        <= mem_write_e;
              dmem_addr      <= addr_aligned_c;
              dmem_be        <= be_c;
              dmem_wdata     <= wdata_c;
              state          <= ACCESS;
            end else begin
              reg_write_m  <= reg_write_e;
              result_src_m <= result_src_e;
              alu_result_m <= alu_result_e;
              read_data_m  <= '0;
              rd_m         <= rd_e;
              pc_plus4_m   <= pc_plus4_e;
            end
          end
        end
        ACCESS: begin
          reg_write_m <= 1'b0;
          if (dmem_ready) begin
            reg_write_m  <= cap_reg_write && !cap_store;
            result_src_m <= cap_result_src;
            alu_result_m <= cap_alu;
            read_data_m  <= cap_store ? '0 : load_format(cap_funct3, dmem_addr[1:0], dmem_rdata);
            rd_m         <= cap_rd;
            pc_plus4_m   <= cap_pc4;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            state        <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
